// File: rtl/traffic_seq_ctrl.sv
// Traffic-light sequencer: RED->GREEN->YELLOW from a per-second countdown, pedestrian
// shortening of GREEN, and a two-digit time-multiplexed readout of the remaining seconds.
module traffic_seq_ctrl #(
  parameter int unsigned CLK_PER_SEC = 1000,
  parameter int unsigned SCAN_DIV    = 64,
  parameter int unsigned RED_T       = 30,
  parameter int unsigned GREEN_T     = 25,
  parameter int unsigned YELLOW_T    = 3,
  parameter int unsigned PED_MIN     = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       ped_req,
  output logic       red,
  output logic       yellow,
  output logic       green,
  output logic       ped_wait,
  output logic [7:0] seg_val,
  output logic       seg_we,
  output logic [1:0] dig_sel
);

  localparam int unsigned SEC_W  = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [SEC_W-1:0]  SEC_LAST  = SEC_W'(CLK_PER_SEC - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  localparam logic [6:0] RED_R    = 7'(RED_T);
  localparam logic [6:0] GREEN_R  = 7'(GREEN_T);
  localparam logic [6:0] YELLOW_R = 7'(YELLOW_T);
  localparam logic [6:0] PED_R    = 7'(PED_MIN);

  if (CLK_PER_SEC < 2 || SCAN_DIV < 1 ||
      RED_T < 1 || RED_T > 99 || GREEN_T < 1 || GREEN_T > 99 ||
      YELLOW_T < 1 || YELLOW_T > 99 ||
      PED_MIN < 1 || PED_MIN > 99 || PED_MIN > GREEN_T) begin : g_param_check
    $error("traffic_seq_ctrl: parameter out of range");
  end

  typedef enum logic [1:0] {
    S_RED    = 2'd0,
    S_GREEN  = 2'd1,
    S_YELLOW = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [6:0]          remain_q, remain_d;
  logic [SEC_W-1:0]    sec_cnt_q, sec_cnt_d;
  logic [SCAN_W-1:0]   scan_cnt_q, scan_cnt_d;
  logic                ped_wait_q, ped_wait_d;
  logic                red_q, red_d;
  logic                yellow_q, yellow_d;
  logic                green_q, green_d;
  logic [7:0]          seg_val_q, seg_val_d;
  logic                seg_we_q, seg_we_d;
  logic [1:0]          dig_sel_q, dig_sel_d;

  logic                tick;
  logic                scan_wrap;
  logic [6:0]          tens;
  logic [6:0]          ones;

  // Second timebase: frozen entirely while disabled, so resuming needs no catch-up tick.
  always_comb begin
    tick      = enable && (sec_cnt_q == SEC_LAST);
    sec_cnt_d = sec_cnt_q;
    if (enable) begin
      sec_cnt_d = tick ? '0 : sec_cnt_q + SEC_W'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    remain_d   = remain_q;
    ped_wait_d = ped_wait_q;
    if (enable) begin
      if (tick && remain_q == 7'd1) begin
        case (state_q)
          S_RED: begin
            state_d    = S_GREEN;
            remain_d   = (ped_wait_q || ped_req) ? PED_R : GREEN_R;
            ped_wait_d = 1'b0;
          end
          S_GREEN: begin
            // A request coinciding with the end of GREEN is simply dropped.
            state_d  = S_YELLOW;
            remain_d = YELLOW_R;
          end
          default: begin
            state_d    = S_RED;
            remain_d   = RED_R;
            ped_wait_d = ped_wait_q | ped_req;
          end
        endcase
      end else begin
        if (tick) begin
          remain_d = remain_q - 7'd1;
        end
        if (ped_req) begin
          if (state_q == S_GREEN) begin
            if (remain_d > PED_R) begin
              remain_d = PED_R;
            end
          end else begin
            ped_wait_d = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    red_d    = (state_d == S_RED);
    yellow_d = (state_d == S_YELLOW);
    green_d  = (state_d == S_GREEN);
  end

  // Digit and its select are computed from the same next-select so they never disagree.
  always_comb begin
    scan_wrap  = (scan_cnt_q == SCAN_LAST);
    scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + SCAN_W'(1);
    dig_sel_d  = scan_wrap ? {dig_sel_q[0], dig_sel_q[1]} : dig_sel_q;
    tens       = remain_q / 7'd10;
    ones       = remain_q % 7'd10;
    if (dig_sel_d == 2'b10) begin
      seg_val_d = {1'b0, tens};
      seg_we_d  = (tens != 7'd0);
    end else begin
      seg_val_d = {1'b0, ones};
      seg_we_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RED;
      remain_q   <= RED_R;
      sec_cnt_q  <= '0;
      scan_cnt_q <= '0;
      ped_wait_q <= 1'b0;
      red_q      <= 1'b1;
      yellow_q   <= 1'b0;
      green_q    <= 1'b0;
      seg_val_q  <= '0;
      seg_we_q   <= 1'b0;
      dig_sel_q  <= 2'b01;
    end else begin
      state_q    <= state_d;
      remain_q   <= remain_d;
      sec_cnt_q  <= sec_cnt_d;
      scan_cnt_q <= scan_cnt_d;
      ped_wait_q <= ped_wait_d;
      red_q      <= red_d;
      yellow_q   <= yellow_d;
      green_q    <= green_d;
      seg_val_q  <= seg_val_d;
      seg_we_q   <= seg_we_d;
      dig_sel_q  <= dig_sel_d;
    end
  end

  assign red      = red_q;
  assign yellow   = yellow_q;
  assign green    = green_q;
  assign ped_wait = ped_wait_q;
  assign seg_val  = seg_val_q;
  assign seg_we   = seg_we_q;
  assign dig_sel  = dig_sel_q;

endmodule

// File: tb/tb_traffic_seq_ctrl.sv
// Bench for traffic_seq_ctrl: directed scenarios plus random traffic, every cycle
// compared against a seconds-level reference model of the intersection.
module tb_traffic_seq_ctrl;

  localparam int CPS = 4;
  localparam int SD  = 2;
  localparam int RT  = 3;
  localparam int GT  = 12;
  localparam int YT  = 2;
  localparam int PM  = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       ped_req = 1'b0;
  logic       red, yellow, green, ped_wait, seg_we;
  logic [7:0] seg_val;
  logic [1:0] dig_sel;

  always #5 clk = ~clk;

  traffic_seq_ctrl #(
    .CLK_PER_SEC(CPS),
    .SCAN_DIV   (SD),
    .RED_T      (RT),
    .GREEN_T    (GT),
    .YELLOW_T   (YT),
    .PED_MIN    (PM)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .ped_req (ped_req),
    .red     (red),
    .yellow  (yellow),
    .green   (green),
    .ped_wait(ped_wait),
    .seg_val (seg_val),
    .seg_we  (seg_we),
    .dig_sel (dig_sel)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: phase 0=RED 1=GREEN 2=YELLOW, seconds left, position in second.
  int m_phase, m_remain, m_sec, m_scan, m_dig, m_shown;
  bit m_pw, m_fresh;
  int dur [3] = '{RT, GT, YT};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic reach(input string tag, input bit ok);
    checks++;
    assert (ok) else begin
      errors++;
      $error("FAIL %s: condition not reached within cycle budget", tag);
    end
  endtask

  task automatic model_edge(input bit r, input bit en, input bit pr);
    bit tick;
    if (r) begin
      m_phase = 0; m_remain = RT; m_sec = 0; m_scan = 0; m_dig = 0;
      m_pw = 0; m_fresh = 1; m_shown = RT;
      return;
    end
    m_fresh = 0;
    m_shown = m_remain;
    if (m_scan == SD - 1) begin
      m_scan = 0;
      m_dig  = 1 - m_dig;
    end else begin
      m_scan++;
    end
    if (en) begin
      tick  = (m_sec == CPS - 1);
      m_sec = tick ? 0 : m_sec + 1;
      if (tick && m_remain == 1) begin
        m_phase = (m_phase + 1) % 3;
        if (m_phase == 1) begin
          m_remain = (m_pw || pr) ? PM : GT;
          m_pw = 0;
        end else begin
          m_remain = dur[m_phase];
          if (m_phase == 0) m_pw = m_pw | pr;
        end
      end else begin
        if (tick) m_remain--;
        if (pr) begin
          if (m_phase == 1) begin
            if (m_remain > PM) m_remain = PM;
          end else begin
            m_pw = 1;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    int ev, ewe;
    ev  = m_fresh ? 0 : (m_dig == 1 ? m_shown / 10 : m_shown % 10);
    ewe = m_fresh ? 0 : ((m_dig == 1 && m_shown / 10 == 0) ? 0 : 1);
    check("red",      red,      m_phase == 0);
    check("green",    green,    m_phase == 1);
    check("yellow",   yellow,   m_phase == 2);
    check("ped_wait", ped_wait, m_pw);
    check("dig_sel",  dig_sel,  (m_dig == 1) ? 2 : 1);
    check("seg_val",  seg_val,  ev);
    check("seg_we",   seg_we,   ewe);
  endtask

  task step(input bit r, input bit en, input bit pr);
    rst = r; enable = en; ped_req = pr;
    model_edge(r, en, pr);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    int n;
    step(1, 1, 0);

    // Phase lengths after reset release.
    n = 0;
    while (red === 1'b1 && n < 100) begin n++; step(0, 1, 0); end
    check("t1_red_len", n, 12);
    n = 0;
    while (green === 1'b1 && n < 100) begin n++; step(0, 1, 0); end
    check("t1_green_len", n, 48);
    n = 0;
    while (yellow === 1'b1 && n < 100) begin n++; step(0, 1, 0); end
    check("t1_yellow_len", n, 8);
    check("t1_red_again", red, 1);

    // Pedestrian in GREEN: shortened at 12, untouched at 3.
    for (n = 0; n < 200 && !(m_phase == 1 && m_remain == 12 && m_sec != CPS - 1); n++) step(0, 1, 0);
    reach("t3_green12", n < 200);
    step(0, 1, 1);
    repeat (4) step(0, 1, 0);
    for (n = 0; n < 200 && !(m_phase == 1 && m_remain == 3 && m_sec != CPS - 1); n++) step(0, 1, 0);
    reach("t3_green3", n < 200);
    step(0, 1, 1);
    repeat (3) step(0, 1, 0);

    // Pedestrian in RED: latched, then short GREEN.
    for (n = 0; n < 200 && m_phase != 0; n++) step(0, 1, 0);
    reach("t4_red", n < 200);
    step(0, 1, 1);
    check("t4_ped_wait_set", ped_wait, 1);
    for (n = 0; n < 200 && m_phase != 1; n++) step(0, 1, 0);
    reach("t4_green", n < 200);
    check("t4_ped_wait_clr", ped_wait, 0);
    n = 0;
    while (green === 1'b1 && n < 100) begin n++; step(0, 1, 0); end
    check("t4_green_len", n, 20);

    // Freeze mid-GREEN at 7 seconds, with button presses that must be ignored.
    for (n = 0; n < 300 && !(m_phase == 1 && m_remain == 7 && m_sec == 1); n++) step(0, 1, 0);
    reach("t5_green7", n < 300);
    for (int i = 0; i < 20; i++) step(0, 0, (i % 3) == 0);
    check("t5_frozen_green", green, 1);
    repeat (10) step(0, 1, 0);

    // Reset mid-YELLOW with a latched request.
    for (n = 0; n < 300 && m_phase != 2; n++) step(0, 1, 0);
    reach("t6_yellow", n < 300);
    step(0, 1, 1);
    check("t6_ped_wait", ped_wait, 1);
    step(1, 1, 1);
    check("t6_red", red, 1);
    check("t6_seg_we", seg_we, 0);
    repeat (14) step(0, 1, 0);

    // Random traffic.
    for (int i = 0; i < 1500; i++)
      step(($urandom % 400) == 0, ($urandom % 8) != 0, ($urandom % 12) == 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
